// File: rtl/sr_pulse_sequencer.sv
// sr_pulse_sequencer: command front-end for a NAND-based SR flip-flop stage.
// Turns set/reset commands into timed, mutually exclusive S/R pulses and
// checks the Q/Q_BAR feedback after each pulse.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (cmd_ready registered)
//   cmd_op[1:0]        00 nop, 01 set, 10 reset, 11 toggle/illegal
//   S, R               registered drives to the flip-flop, never both high
//   q_fb, q_bar_fb     flip-flop feedback
//   done, err          one-cycle completion / failure pulses (coincident)
//   err_cnt[CNT_W-1:0] saturating count of err pulses
//
// Optional feature: define SR_SEQ_TOGGLE_EN to make op 11 a toggle that
// runs as a set when q_fb=0, a reset when q_fb=1, and is rejected as
// illegal when q_fb==q_bar_fb at accept. Undefined: op 11 is illegal.

module sr_pulse_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    output logic             S,
    output logic             R,
    input  logic             q_fb,
    input  logic             q_bar_fb,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        GAP
    } state_t;

    // Resolved meaning of a command once it has been accepted.
    typedef enum logic [1:0] {
        K_NOP,
        K_SET,
        K_RST,
        K_ILL
    } kind_t;

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) + 1 : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) + 1 : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t          state;
    kind_t           kind;
    kind_t           acc_kind;
    logic [PW-1:0]   pulse_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            chk_fail;
    logic            accept;

    assign accept = cmd_valid & cmd_ready;

    // Decode of the incoming op; only consulted on the accept edge.
    always_comb begin
        acc_kind = K_ILL;
        case (cmd_op)
            2'b00:   acc_kind = K_NOP;
            2'b01:   acc_kind = K_SET;
            2'b10:   acc_kind = K_RST;
            default: begin
`ifdef SR_SEQ_TOGGLE_EN
                // Toggle needs a trustworthy current state to invert.
                if (q_fb == q_bar_fb)
                    acc_kind = K_ILL;
                else if (q_fb)
                    acc_kind = K_RST;
                else
                    acc_kind = K_SET;
`else
                acc_kind = K_ILL;
`endif
            end
        endcase
    end

    // Feedback check; q_fb==q_bar_fb fails both polarities by construction.
    always_comb begin
        chk_fail = 1'b0;
        case (kind)
            K_SET:   chk_fail = !(q_fb && !q_bar_fb);
            K_RST:   chk_fail = !(!q_fb && q_bar_fb);
            K_ILL:   chk_fail = 1'b1;
            default: chk_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kind      <= K_NOP;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            cmd_ready <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        kind      <= acc_kind;
                        pulse_cnt <= PULSE_LAST;
                        if (acc_kind == K_SET) begin
                            S     <= 1'b1;
                            R     <= 1'b0;
                            state <= DRIVE;
                        end else if (acc_kind == K_RST) begin
                            S     <= 1'b0;
                            R     <= 1'b1;
                            state <= DRIVE;
                        end else begin
                            // nop and illegal ops report on the next edge.
                            S     <= 1'b0;
                            R     <= 1'b0;
                            state <= CHECK;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset.
                        cmd_ready <= 1'b1;
                    end
                end

                DRIVE: begin
                    if (pulse_cnt == '0) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        state <= CHECK;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end

                CHECK: begin
                    done <= 1'b1;
                    err  <= chk_fail;
                    if (chk_fail && (err_cnt != '1))
                        err_cnt <= err_cnt + 1'b1;
                    if (GAP_CYCLES == 0) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= GAP_LAST;
                        state   <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    S     <= 1'b0;
                    R     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// tb_sr_pulse_sequencer: directed and random checks of sr_pulse_sequencer
// against a cycle-window reference model and a behavioural SR flip-flop.

module tb_sr_pulse_sequencer;

    localparam int P = 4;
    localparam int G = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready, S, R, done, err;
    logic [7:0] err_cnt;
    logic       q_fb, q_bar_fb;

    logic ff_q = 1'b0;
    logic stuck_en, stuck_val;
    always @(posedge clk) begin
        if (S) ff_q <= 1'b1;
        else if (R) ff_q <= 1'b0;
    end
    assign q_fb     = stuck_en ? stuck_val : ff_q;
    assign q_bar_fb = ~q_fb;

    sr_pulse_sequencer u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .S(S), .R(R), .q_fb(q_fb), .q_bar_fb(q_bar_fb),
        .done(done), .err(err), .err_cnt(err_cnt)
    );

    logic       b_valid;
    logic [1:0] b_op;
    logic       b_ready, b_S, b_R, b_done, b_err;
    logic [1:0] b_cnt;
    logic       b_q = 1'b0;
    logic       b_eq;
    logic       b_qfb, b_qbfb;
    always @(posedge clk) begin
        if (b_S) b_q <= 1'b1;
        else if (b_R) b_q <= 1'b0;
    end
    assign b_qfb  = b_eq ? 1'b0 : b_q;
    assign b_qbfb = b_eq ? 1'b0 : ~b_q;

    sr_pulse_sequencer #(.PULSE_CYCLES(4), .GAP_CYCLES(0), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
        .S(b_S), .R(b_R), .q_fb(b_qfb), .q_bar_fb(b_qbfb),
        .done(b_done), .err(b_err), .err_cnt(b_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] op);
        wait_rdy();
        cmd_valid = 1'b1;
        cmd_op    = op;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic b_issue(input logic [1:0] op);
        int n = 0;
        while (b_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("b_ready_wait", 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        b_op    = op;
        step();
        b_valid = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        int acc, dones, lim;
        int rdy_at, t0, kind, done_at, mcnt;
        logic eb, xr, xs, xrr, xd;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        stuck_en = 1'b0; stuck_val = 1'b0;
        b_valid = 1'b0; b_op = 2'b00; b_eq = 1'b0;
        repeat (3) step();

        chk("rst_S", 32'(S), 0);
        chk("rst_R", 32'(R), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // Set command: pulse window, done timing, ready return.
        issue(2'b01);
        for (int k = 0; k < 9; k++) begin
            chk("set_S", 32'(S), 32'(k < P));
            chk("set_R", 32'(R), 0);
            chk("set_done", 32'(done), 32'(k == P + 1));
            chk("set_err", 32'(err), 0);
            chk("set_ready", 32'(cmd_ready), 32'(k >= P + 1 + G));
            step();
        end
        chk("set_q", 32'(q_fb), 1);
        exp_cnt = 0;

        // Reset command with Q stuck high.
        stuck_en = 1'b1; stuck_val = 1'b1;
        issue(2'b10);
        for (int k = 0; k < 9; k++) begin
            chk("rst_op_R", 32'(R), 32'(k < P));
            chk("rst_op_S", 32'(S), 0);
            chk("rst_op_done", 32'(done), 32'(k == P + 1));
            chk("rst_op_err", 32'(err), 32'(k == P + 1));
            chk("rst_op_ready", 32'(cmd_ready), 32'(k >= P + 1 + G));
            step();
        end
        stuck_en = 1'b0;
        exp_cnt++;
        chk("stuck_cnt", 32'(err_cnt), 32'(exp_cnt));

`ifndef SR_SEQ_TOGGLE_EN
        issue(2'b11);
        for (int k = 0; k < 5; k++) begin
            chk("ill_S", 32'(S), 0);
            chk("ill_R", 32'(R), 0);
            chk("ill_done", 32'(done), 32'(k == 1));
            chk("ill_err", 32'(err), 32'(k == 1));
            chk("ill_ready", 32'(cmd_ready), 32'(k >= 1 + G));
            step();
        end
        exp_cnt++;
        chk("ill_cnt", 32'(err_cnt), 32'(exp_cnt));
`else
        issue(2'b01);
        repeat (10) step();
        issue(2'b11);
        for (int k = 0; k < 9; k++) begin
            chk("tog_R", 32'(R), 32'(k < P));
            chk("tog_S", 32'(S), 0);
            chk("tog_done", 32'(done), 32'(k == P + 1));
            chk("tog_err", 32'(err), 0);
            step();
        end
        chk("tog_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif

        // Asynchronous reset in the middle of a set pulse.
        issue(2'b01);
        step();
        step();
        chk("pre_rst_S", 32'(S), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_S", 32'(S), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        chk("mid_rst_cnt", 32'(err_cnt), 0);
        chk("mid_rst_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_S", 32'(S), 0);

        // Random ops with cmd_valid held high, against a window model.
        acc = 0; dones = 0; lim = 0;
        rdy_at = cyc; t0 = -1000; kind = 0; done_at = -1000;
        eb = 1'b0; mcnt = 0;
        while ((acc < 1000 || cyc <= done_at) && lim < 20000) begin
            xr  = (cyc >= rdy_at);
            xs  = (kind == 1) && (cyc >= t0) && (cyc < t0 + P);
            xrr = (kind == 2) && (cyc >= t0) && (cyc < t0 + P);
            xd  = (cyc == done_at);
            if (xd && eb && mcnt < 255) mcnt++;
            chk("rnd_ready", 32'(cmd_ready), 32'(xr));
            chk("rnd_S", 32'(S), 32'(xs));
            chk("rnd_R", 32'(R), 32'(xrr));
            chk("rnd_SR", 32'(S & R), 0);
            chk("rnd_done", 32'(done), 32'(xd));
            chk("rnd_err", 32'(err), 32'(xd && eb));
            chk("rnd_cnt", 32'(err_cnt), 32'(mcnt));
            if (done === 1'b1) dones++;
            cmd_valid = (acc < 1000);
            cmd_op    = 2'($urandom_range(0, 3));
            if (xr && cmd_valid) begin
                t0 = cyc + 1;
                kind = int'(cmd_op);
`ifdef SR_SEQ_TOGGLE_EN
                if (kind == 3 && q_fb !== q_bar_fb)
                    kind = q_fb ? 2 : 1;
`endif
                eb = (kind == 3);
                done_at = t0 + ((kind == 1 || kind == 2) ? P + 1 : 1);
                rdy_at = done_at + G;
                acc++;
            end
            step();
            lim++;
        end
        cmd_valid = 1'b0;
        chk("rnd_bound", 32'(lim < 20000), 1);
        chk("rnd_one_done_per_accept", 32'(dones), 32'(acc));

        // CNT_W=2 saturation via impossible feedback (Q==Q_BAR).
        b_eq = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            b_issue(2'b01);
            repeat (6) step();
            chk("b_sat_cnt", 32'(b_cnt), 32'((i < 3) ? i : 3));
        end
        b_eq = 1'b0;

        // GAP_CYCLES=0: back-to-back sets with valid held high.
        b_issue(2'b01);
        repeat (8) step();
        b_valid = 1'b1;
        b_op    = 2'b01;
        while (b_ready !== 1'b1 && lim < 20040) begin
            step();
            lim++;
        end
        step();
        for (int k = 0; k < 10; k++) begin
            if (k == 6) b_valid = 1'b0;
            chk("b2b_S", 32'(b_S), 32'(k < P || k >= P + 2));
            chk("b2b_R", 32'(b_R), 0);
            chk("b2b_ready", 32'(b_ready), 32'(k == P + 1));
            chk("b2b_done", 32'(b_done), 32'(k == P + 1));
            chk("b2b_err", 32'(b_err), 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
